// File: rtl/dac_pkg.sv
// Shared definitions for the DAC transmit path: FSM state encoding, saturation
// bounds and the midscale word. The output coding is selected by the
// DAC_OFFSET_BINARY_EN macro (defined: offset binary, undefined: two's complement).
package dac_pkg;

  // Default DAC word width; the top level may override it.
  localparam int DAC_W_DEF = 10;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } tx_state_e;

  // Largest positive value representable in a signed word of width w.
  function automatic int dac_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative value representable in a signed word of width w.
  function automatic int dac_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Saturation bounds for the default width.
  localparam int DAC_MAX = dac_max(DAC_W_DEF);
  localparam int DAC_MIN = dac_min(DAC_W_DEF);

  // Output coding. Offset binary is two's complement with the MSB inverted,
  // which moves midscale from all-zeros to 1000...0.
`ifdef DAC_OFFSET_BINARY_EN
  localparam bit                     OFFSET_BINARY = 1'b1;
  localparam logic [DAC_W_DEF-1:0]   DAC_MIDSCALE  = 10'h200;
`else
  localparam bit                     OFFSET_BINARY = 1'b0;
  localparam logic [DAC_W_DEF-1:0]   DAC_MIDSCALE  = 10'h000;
`endif

endpackage

// File: rtl/dac_tx_fifo.sv
// Synchronous single-clock FIFO holding saturated DAC words between the
// processing chain and the paced DAC output. Flush empties it in one cycle.
module dac_tx_fifo #(
  parameter int W  = 10,
  parameter int AW = 4
) (
  input  logic          clk_dac,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // Guard against overflow/underflow locally so the FIFO is safe on its own.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the storage array is deliberately not reset; only pointers and count
  // define validity, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk_dac) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_interface.sv
// Transmit-side DAC interface: accepts 32-bit signed samples over valid/ready,
// saturates them to the DAC range, buffers them and paces them out at
// clk_dac/RATE_DIV once the FIFO has primed. Reports clipping and a sticky
// underflow flag. DAC_OFFSET_BINARY_EN selects offset-binary output coding.
module dac_interface
  import dac_pkg::*;
#(
  parameter int DAC_W       = DAC_W_DEF,
  parameter int FIFO_AW     = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int RATE_DIV    = 1,
  parameter int UF_THRESH   = 3
) (
  input  logic               clk_dac,
  input  logic               rst,
  input  logic               tx_enable,
  input  logic [31:0]        tx_samples,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [DAC_W-1:0]   dac_data,
  output logic               dac_valid,
  output logic               dac_sleep,
  output logic               tx_active,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               clip_detect,
  output logic               underflow_detect
);

  localparam int LVL_W = FIFO_AW + 1;
  localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int UF_W  = $clog2(UF_THRESH + 1);

  localparam logic signed [31:0] SAT_MAX   = 32'(dac_max(DAC_W));
  localparam logic signed [31:0] SAT_MIN   = 32'(dac_min(DAC_W));
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RATE_DIV - 1);
  localparam logic [UF_W-1:0]    UF_LIMIT  = UF_W'(UF_THRESH);
  localparam logic [LVL_W-1:0]   PRIME_LVL = LVL_W'(PRIME_LEVEL);
  localparam logic [DAC_W-1:0]   MIDSCALE  =
    OFFSET_BINARY ? {1'b1, {(DAC_W-1){1'b0}}} : '0;

  tx_state_e          state;
  tx_state_e          state_next;
  logic               flush;
  logic               strobe;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DAC_W-1:0]   fifo_rd_data;
  logic [DAC_W-1:0]   sat_word;
  logic               sat_clip;
  logic [CNT_W-1:0]   rate_cnt;
  logic [UF_W-1:0]    uf_count;
  logic [UF_W-1:0]    uf_next;

  // Convert a stored two's-complement word to the DAC's output coding.
  function automatic logic [DAC_W-1:0] encode(input logic [DAC_W-1:0] word);
    return {word[DAC_W-1] ^ OFFSET_BINARY, word[DAC_W-2:0]};
  endfunction

  // Write-side saturation of the incoming 32-bit sample to the DAC range.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sat_word = tx_samples[DAC_W-1:0];
    sat_clip = 1'b0;
    if ($signed(tx_samples) > SAT_MAX) begin
      sat_word = SAT_MAX[DAC_W-1:0];
      sat_clip = 1'b1;
    end else if ($signed(tx_samples) < SAT_MIN) begin
      sat_word = SAT_MIN[DAC_W-1:0];
      sat_clip = 1'b1;
    end
  end

  // Handshake: ready depends only on FIFO space; the flush cycle drops writes.
  assign tx_ready = ~fifo_full;
  assign push     = tx_valid & ~fifo_full & ~flush;

  // Pacing: a strobe every RATE_DIV cycles while running and still enabled.
  assign strobe   = (state == RUN) & tx_enable & (rate_cnt == CNT_LAST);
  assign pop      = strobe & ~fifo_empty;

  assign dac_sleep = (state != RUN);
  assign tx_active = (state == RUN);

  dac_tx_fifo #(
    .W  (DAC_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_dac (clk_dac),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (sat_word),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // FSM state register.
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; leaving PRIME/RUN on disable flushes the FIFO.
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable) begin
          state_next = PRIME;
        end
      end
      PRIME: begin
        if (!tx_enable) begin
          state_next = IDLE;
          flush      = 1'b1;
        end else if (fifo_level >= PRIME_LVL) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!tx_enable) begin
          state_next = IDLE;
          flush      = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Rate divider: free-running while running, parked at zero otherwise.
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      rate_cnt <= '0;
    end else if ((state == RUN) && tx_enable) begin
      rate_cnt <= (rate_cnt == CNT_LAST) ? '0 : rate_cnt + CNT_W'(1);
    end else begin
      rate_cnt <= '0;
    end
  end

  // Saturating underflow count candidate for an empty strobe.
  assign uf_next = (uf_count == UF_LIMIT) ? uf_count : uf_count + UF_W'(1);

  // Output word, strobe, clip pulse and underflow tracking.
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      dac_data         <= MIDSCALE;
      dac_valid        <= 1'b0;
      clip_detect      <= 1'b0;
      uf_count         <= '0;
      underflow_detect <= 1'b0;
    end else begin
      dac_valid   <= 1'b0;
      clip_detect <= push & sat_clip;
      if (flush) begin
        dac_data <= MIDSCALE;
      end else if (strobe) begin
        dac_valid <= 1'b1;
        if (!fifo_empty) begin
          dac_data <= encode(fifo_rd_data);
          uf_count <= '0;
        end else begin
          // Starved: hold the DAC at midscale and count the miss.
          dac_data <= MIDSCALE;
          uf_count <= uf_next;
          if (uf_next == UF_LIMIT) begin
            underflow_detect <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_interface.sv
// Directed testbench for dac_interface. Two instances share clock and reset:
// u_dut1 runs at RATE_DIV=1, u_dut4 at RATE_DIV=4 for pacing/backpressure/stop.
module tb_dac_interface;

  logic        clk_dac = 1'b0;
  logic        rst;

  logic        en1, val1, ready1, dvalid1, sleep1, active1, clip1, uf1;
  logic [31:0] samp1;
  logic [9:0]  data1;
  logic [4:0]  level1;

  logic        en4, val4, ready4, dvalid4, sleep4, active4, clip4, uf4;
  logic [31:0] samp4;
  logic [9:0]  data4;
  logic [4:0]  level4;

  int tests = 0;
  int fails = 0;

  int clip_in   [5] = '{1000, -2000, 511, -512, 512};
  int clip_word [6] = '{0, 511, -512, 511, -512, 511};
  bit clip_exp  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk_dac = ~clk_dac;

  dac_interface #(.RATE_DIV(1)) u_dut1 (
    .clk_dac          (clk_dac),
    .rst              (rst),
    .tx_enable        (en1),
    .tx_samples       (samp1),
    .tx_valid         (val1),
    .tx_ready         (ready1),
    .dac_data         (data1),
    .dac_valid        (dvalid1),
    .dac_sleep        (sleep1),
    .tx_active        (active1),
    .fifo_level       (level1),
    .clip_detect      (clip1),
    .underflow_detect (uf1)
  );

  dac_interface #(.RATE_DIV(4)) u_dut4 (
    .clk_dac          (clk_dac),
    .rst              (rst),
    .tx_enable        (en4),
    .tx_samples       (samp4),
    .tx_valid         (val4),
    .tx_ready         (ready4),
    .dac_data         (data4),
    .dac_valid        (dvalid4),
    .dac_sleep        (sleep4),
    .tx_active        (active4),
    .fifo_level       (level4),
    .clip_detect      (clip4),
    .underflow_detect (uf4)
  );

  // Expected DAC coding of a signed value (two's complement or offset binary).
  function automatic logic [9:0] enc(input int v);
    logic [9:0] w;
    w = v[9:0];
`ifdef DAC_OFFSET_BINARY_EN
    w[9] = ~w[9];
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_dac);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en1 = 0; val1 = 0; samp1 = '0;
    en4 = 0; val4 = 0; samp4 = '0;
    tick();
    tick();
    tests++; if (data1 !== enc(0)) begin fails++; $display("FAIL reset_data: got %h expected %h", data1, enc(0)); end
    tests++; if (dvalid1 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dvalid1); end
    tests++; if (sleep1 !== 1'b1) begin fails++; $display("FAIL reset_sleep: got %b expected 1", sleep1); end
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready1); end
    tests++; if (level1 !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level1); end
    tests++; if (uf1 !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b expected 0", uf1); end
    tests++; if ({active1, clip1} !== 2'b00) begin fails++; $display("FAIL reset_active_clip: got %b expected 00", {active1, clip1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_prime_run();
    en1  = 1'b1;
    val1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      samp1 = 32'(k);
      tick();
    end
    val1 = 1'b0;
    tests++; if (level1 !== 5'd8) begin fails++; $display("FAIL prime_level: got %0d expected 8", level1); end
    tests++; if ({active1, sleep1} !== 2'b01) begin fails++; $display("FAIL prime_state: got active/sleep %b expected 01", {active1, sleep1}); end
    tick();
    tests++; if ({active1, sleep1, dvalid1} !== 3'b100) begin fails++; $display("FAIL run_entry: got active/sleep/valid %b expected 100", {active1, sleep1, dvalid1}); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests++;
      if (dvalid1 !== 1'b1 || data1 !== enc(k)) begin
        fails++;
        $display("FAIL run_word%0d: got valid %b data %h expected valid 1 data %h", k, dvalid1, data1, enc(k));
      end
    end
  endtask

  task automatic test_underflow();
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++;
      if (dvalid1 !== 1'b1 || data1 !== enc(0) || uf1 !== (i == 3)) begin
        fails++;
        $display("FAIL underflow_strobe%0d: got valid %b data %h flag %b expected 1 %h %b", i, dvalid1, data1, uf1, enc(0), (i == 3));
      end
    end
    // A write during an empty strobe is stored, not bypassed.
    val1  = 1'b1;
    samp1 = 32'd42;
    tick();
    val1  = 1'b0;
    tests++; if (data1 !== enc(0)) begin fails++; $display("FAIL no_bypass: got %h expected %h", data1, enc(0)); end
    tick();
    tests++; if (dvalid1 !== 1'b1 || data1 !== enc(42)) begin fails++; $display("FAIL refill_word: got valid %b data %h expected 1 %h", dvalid1, data1, enc(42)); end
    tests++; if (uf1 !== 1'b1) begin fails++; $display("FAIL underflow_sticky: got %b expected 1", uf1); end
  endtask

  task automatic test_clipping();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        val1  = 1'b1;
        samp1 = 32'(clip_in[i]);
      end else begin
        val1 = 1'b0;
      end
      tick();
      tests++;
      if (clip1 !== clip_exp[i] || data1 !== enc(clip_word[i]) || dvalid1 !== 1'b1) begin
        fails++;
        $display("FAIL clip_step%0d: got clip %b data %h valid %b expected %b %h 1", i, clip1, data1, dvalid1, clip_exp[i], enc(clip_word[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int in_idx = 0;
    int out_idx = 0;
    int max_level = 0;
    int ready_err = 0;
    bit accept;
    en4 = 1'b1;
    for (int cyc = 0; cyc < 300 && out_idx < 20; cyc++) begin
      if (dvalid4) begin
        tests++;
        if (data4 !== enc(100 + out_idx)) begin
          fails++;
          $display("FAIL bp_word%0d: got %h expected %h", out_idx, data4, enc(100 + out_idx));
        end
        out_idx++;
      end
      if (int'(level4) > max_level) max_level = int'(level4);
      if (ready4 !== (level4 != 5'd16)) ready_err++;
      if (in_idx < 20) begin
        val4  = 1'b1;
        samp4 = 32'(100 + in_idx);
      end else begin
        val4 = 1'b0;
      end
      accept = val4 && ready4;
      tick();
      if (accept) in_idx++;
    end
    val4 = 1'b0;
    tests++; if (out_idx != 20) begin fails++; $display("FAIL bp_count: got %0d words expected 20", out_idx); end
    tests++; if (max_level != 16) begin fails++; $display("FAIL bp_max_level: got %0d expected 16", max_level); end
    tests++; if (ready_err != 0) begin fails++; $display("FAIL bp_ready: got %0d bad cycles expected 0", ready_err); end
  endtask

  task automatic test_stop();
    bit hit = 1'b0;
    int bad = 0;
    val4 = 1'b1;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      samp4 = 32'(200 + cyc);
      tick();
      if (level4 == 5'd5) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL stop_reach_level5: got level %0d expected 5", level4); end
    // Disable with a write still offered; it must be dropped.
    en4   = 1'b0;
    samp4 = 32'd250;
    tick();
    val4 = 1'b0;
    tests++; if (level4 !== 5'd0) begin fails++; $display("FAIL stop_level: got %0d expected 0", level4); end
    tests++; if ({sleep4, active4, dvalid4} !== 3'b100) begin fails++; $display("FAIL stop_state: got sleep/active/valid %b expected 100", {sleep4, active4, dvalid4}); end
    tests++; if (data4 !== enc(0)) begin fails++; $display("FAIL stop_data: got %h expected %h", data4, enc(0)); end
    // Re-enable without data: must wait in PRIME.
    en4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (active4 !== 1'b0 || dvalid4 !== 1'b0 || sleep4 !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL reprime_wait: got %0d active cycles expected 0", bad); end
    val4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      samp4 = 32'(300 + k);
      tick();
    end
    val4 = 1'b0;
    tick();
    tests++; if (active4 !== 1'b1) begin fails++; $display("FAIL reprime_run: got %b expected 1", active4); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dvalid4 !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rate_gap: got %0d early strobes expected 0", bad); end
    tick();
    tests++; if (dvalid4 !== 1'b1 || data4 !== enc(300)) begin fails++; $display("FAIL rate_first_word: got valid %b data %h expected 1 %h", dvalid4, data4, enc(300)); end
  endtask

  task automatic test_mid_reset();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (uf1 !== 1'b0) begin fails++; $display("FAIL midrst_underflow: got %b expected 0", uf1); end
    tests++; if (level4 !== 5'd0 || active4 !== 1'b0) begin fails++; $display("FAIL midrst_state: got level %0d active %b expected 0 0", level4, active4); end
    tests++; if (data4 !== enc(0) || dvalid4 !== 1'b0) begin fails++; $display("FAIL midrst_data: got %h valid %b expected %h 0", data4, dvalid4, enc(0)); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_prime_run();
    test_underflow();
    test_clipping();
    test_backpressure();
    test_stop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
